// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the transmit encoder and the byte parser.
// Holds the command codes carried in status-byte bits 6:4, the
// system-reset byte, the encoder FSM state type, and msg_len(), which maps a
// command to its total message length in bytes.
package midi_pkg;

    typedef enum logic [2:0] {
        CMD_NOTE_OFF   = 3'b000,
        CMD_NOTE_ON    = 3'b001,
        CMD_POLY_PRESS = 3'b010,
        CMD_CTRL       = 3'b011,
        CMD_PROG       = 3'b100,
        CMD_CHAN_PRESS = 3'b101,
        CMD_PITCH      = 3'b110,
        CMD_SYSTEM     = 3'b111
    } midi_cmd_e;

    localparam logic [7:0] SYS_RESET = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATUS = 2'd1,
        ST_DATA1  = 2'd2,
        ST_DATA2  = 2'd3
    } tx_state_e;

    // Total bytes on the wire for a command, status byte included.
    function automatic logic [1:0] msg_len(input logic [2:0] cmd);
        logic [1:0] len;
        case (cmd)
            CMD_PROG, CMD_CHAN_PRESS: len = 2'd2;
            CMD_SYSTEM:               len = 2'd1;
            default:                  len = 2'd3;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/midi_tx_encoder_if.sv
// Event-request and byte-stream bundle of the MIDI transmit encoder.
//   req_*    : one decoded event per valid/ready handshake
//   tx_*     : serialised bytes towards the UART, valid/ready handshake
//   busy     : a message is in progress
// Modport slave is the encoder side, master is the event source / UART side.
interface midi_tx_encoder_if;

    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_cmd;
    logic [3:0] req_channel;
    logic [6:0] req_note;
    logic [6:0] req_velocity;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;

    modport slave (
        input  req_valid, req_cmd, req_channel, req_note, req_velocity, tx_ready,
        output req_ready, tx_valid, tx_data, busy
    );

    modport master (
        output req_valid, req_cmd, req_channel, req_note, req_velocity, tx_ready,
        input  req_ready, tx_valid, tx_data, busy
    );

endinterface

// File: rtl/midi_rs_timer.sv
// Running-status inactivity timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   byte_xfer  : a byte was handed to the UART this cycle (restarts the count)
//   rs_expire  : count has reached RS_TIMEOUT; running status is stale
// The counter saturates, so rs_expire stays high until the next byte moves.
module midi_rs_timer #(
    parameter int unsigned RS_TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic byte_xfer,
    output logic rs_expire
);

    localparam int CNT_W = $clog2(RS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RS_TIMEOUT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (byte_xfer) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign rs_expire = (cnt == CNT_MAX);

endmodule

// File: rtl/midi_tx_encoder.sv
// MIDI transmit encoder: serialises one decoded event (command, channel,
// note, velocity) into a 1..3 byte MIDI stream for a UART transmitter, with
// optional running-status suppression of repeated status bytes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : midi_tx_encoder_if.slave (request handshake, tx byte
//                handshake, busy)
module midi_tx_encoder #(
    parameter bit          RUNNING_STATUS = 1'b1,
    parameter int unsigned RS_TIMEOUT     = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    midi_tx_encoder_if.slave   bus
);

    import midi_pkg::*;

    tx_state_e  state, state_nxt;
    logic       tx_valid_q, tx_valid_nxt;
    logic [7:0] tx_data_q, tx_data_nxt;

    logic [7:0] status_q;
    logic [6:0] note_q;
    logic [6:0] vel_q;
    logic [1:0] len_q;

    logic [7:0] rs_last;
    logic       rs_valid;
    logic       rs_expire;

    logic       accept;
    logic       xfer;
    logic [7:0] req_status;
    logic [1:0] req_len;
    logic [7:0] req_first_data;
    logic [7:0] cap_first_data;
    logic       suppress;

    assign accept     = bus.req_valid && bus.req_ready;
    assign xfer       = tx_valid_q && bus.tx_ready;
    assign req_status = {1'b1, bus.req_cmd, bus.req_channel};
    assign req_len    = msg_len(bus.req_cmd);

    // Two-byte commands carry velocity as their only data byte.
    assign req_first_data = (req_len == 2'd2) ? {1'b0, bus.req_velocity}
                                              : {1'b0, bus.req_note};
    assign cap_first_data = (len_q == 2'd2) ? {1'b0, vel_q} : {1'b0, note_q};

    // System messages never use running status; every other command has at
    // least one data byte, so a suppressed message still has bytes to send.
    assign suppress = RUNNING_STATUS && rs_valid && (req_status == rs_last)
                      && (bus.req_cmd != CMD_SYSTEM);

    // Ready is forced low while reset is held, and rises as soon as it lifts.
    assign bus.req_ready = rst_n && (state == ST_IDLE);
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state      <= state_nxt;
            tx_valid_q <= tx_valid_nxt;
            tx_data_q  <= tx_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_valid_nxt = tx_valid_q;
        tx_data_nxt  = tx_data_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    tx_valid_nxt = 1'b1;
                    if (suppress) begin
                        state_nxt   = ST_DATA1;
                        tx_data_nxt = req_first_data;
                    end else begin
                        state_nxt   = ST_STATUS;
                        tx_data_nxt = req_status;
                    end
                end
            end
            ST_STATUS: begin
                if (xfer) begin
                    if (len_q > 2'd1) begin
                        state_nxt   = ST_DATA1;
                        tx_data_nxt = cap_first_data;
                    end else begin
                        state_nxt    = ST_IDLE;
                        tx_valid_nxt = 1'b0;
                    end
                end
            end
            ST_DATA1: begin
                if (xfer) begin
                    if (len_q == 2'd3) begin
                        state_nxt   = ST_DATA2;
                        tx_data_nxt = {1'b0, vel_q};
                    end else begin
                        state_nxt    = ST_IDLE;
                        tx_valid_nxt = 1'b0;
                    end
                end
            end
            ST_DATA2: begin
                if (xfer) begin
                    state_nxt    = ST_IDLE;
                    tx_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                tx_valid_nxt = 1'b0;
            end
        endcase
    end

    // Event fields are only read while a message is in flight, so they need
    // no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            status_q <= req_status;
            note_q   <= bus.req_note;
            vel_q    <= bus.req_velocity;
            len_q    <= req_len;
        end
    end

    // A sent status byte arms running status; a system message or a long
    // quiet period disarms it. A status transfer wins over a stale expire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_valid <= 1'b0;
            rs_last  <= 8'h00;
        end else if ((state == ST_STATUS) && xfer) begin
            if (status_q[6:4] == CMD_SYSTEM) begin
                rs_valid <= 1'b0;
            end else begin
                rs_valid <= 1'b1;
                rs_last  <= status_q;
            end
        end else if (rs_expire) begin
            rs_valid <= 1'b0;
        end
    end

    midi_rs_timer #(
        .RS_TIMEOUT (RS_TIMEOUT)
    ) u_rs_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_xfer (xfer),
        .rs_expire (rs_expire)
    );

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Directed bench for midi_tx_encoder. Two instances share stimulus: one with
// running status disabled, one enabled with a 16-cycle timeout; sel chooses
// which one sees req_valid and which one is observed.
module tb_midi_tx_encoder;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       req_valid;
    logic [2:0] req_cmd;
    logic [3:0] req_channel;
    logic [6:0] req_note;
    logic [6:0] req_velocity;
    logic       tx_ready;

    logic       o_req_ready;
    logic       o_tx_valid;
    logic [7:0] o_tx_data;
    logic       o_busy;

    int total;
    int bad;

    midi_tx_encoder_if ifa ();
    midi_tx_encoder_if ifb ();

    assign ifa.req_valid    = req_valid & ~sel;
    assign ifa.req_cmd      = req_cmd;
    assign ifa.req_channel  = req_channel;
    assign ifa.req_note     = req_note;
    assign ifa.req_velocity = req_velocity;
    assign ifa.tx_ready     = tx_ready;

    assign ifb.req_valid    = req_valid & sel;
    assign ifb.req_cmd      = req_cmd;
    assign ifb.req_channel  = req_channel;
    assign ifb.req_note     = req_note;
    assign ifb.req_velocity = req_velocity;
    assign ifb.tx_ready     = tx_ready;

    assign o_req_ready = sel ? ifb.req_ready : ifa.req_ready;
    assign o_tx_valid  = sel ? ifb.tx_valid  : ifa.tx_valid;
    assign o_tx_data   = sel ? ifb.tx_data   : ifa.tx_data;
    assign o_busy      = sel ? ifb.busy      : ifa.busy;

    midi_tx_encoder #(.RUNNING_STATUS(1'b0), .RS_TIMEOUT(16)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    midi_tx_encoder #(.RUNNING_STATUS(1'b1), .RS_TIMEOUT(16)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one event and follow its bytes with tx_ready held high.
    task automatic send_msg(input string tag, input logic [2:0] cmd, input logic [3:0] ch,
                            input logic [6:0] note, input logic [6:0] vel, input int n,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp_b [3];
        exp_b[0] = b0;
        exp_b[1] = b1;
        exp_b[2] = b2;
        @(negedge clk);
        chk({tag, " ready_before"}, 32'(o_req_ready), 32'd1);
        req_cmd      = cmd;
        req_channel  = ch;
        req_note     = note;
        req_velocity = vel;
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s valid%0d", tag, i), 32'(o_tx_valid), 32'd1);
            chk($sformatf("%s byte%0d", tag, i), 32'(o_tx_data), 32'(exp_b[i]));
            chk($sformatf("%s busy%0d", tag, i), 32'(o_busy), 32'd1);
            chk($sformatf("%s ready_low%0d", tag, i), 32'(o_req_ready), 32'd0);
            if (i < n - 1) @(negedge clk);
        end
        @(negedge clk);
        chk({tag, " done_valid"}, 32'(o_tx_valid), 32'd0);
        chk({tag, " done_ready"}, 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total        = 0;
        bad          = 0;
        sel          = 1'b0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_cmd      = 3'd0;
        req_channel  = 4'd0;
        req_note     = 7'd0;
        req_velocity = 7'd0;
        tx_ready     = 1'b1;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("rst%0d ready", s), 32'(o_req_ready), 32'd0);
            chk($sformatf("rst%0d valid", s), 32'(o_tx_valid), 32'd0);
            chk($sformatf("rst%0d data", s), 32'(o_tx_data), 32'h00);
            chk($sformatf("rst%0d busy", s), 32'(o_busy), 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel ready", 32'(o_req_ready), 32'd1);

        // No running status: status byte repeats every time.
        sel = 1'b0;
        send_msg("non1", 3'b001, 4'd3, 7'd60, 7'd100, 3, 8'h93, 8'h3C, 8'h64);
        send_msg("non2", 3'b001, 4'd3, 7'd60, 7'd100, 3, 8'h93, 8'h3C, 8'h64);
        send_msg("chp",  3'b101, 4'd0, 7'h55, 7'h7F, 2, 8'hD0, 8'h7F, 8'h00);
        send_msg("prog", 3'b100, 4'd9, 7'h12, 7'h05, 2, 8'hC9, 8'h05, 8'h00);

        // Running status on instance B.
        sel = 1'b1;
        send_msg("rs1", 3'b001, 4'd1, 7'h40, 7'h50, 3, 8'h91, 8'h40, 8'h50);
        send_msg("rs2", 3'b001, 4'd1, 7'h41, 7'h50, 2, 8'h41, 8'h50, 8'h00);
        repeat (20) @(negedge clk);
        send_msg("rs_to", 3'b001, 4'd1, 7'h41, 7'h50, 3, 8'h91, 8'h41, 8'h50);
        send_msg("rs3", 3'b001, 4'd1, 7'h42, 7'h50, 2, 8'h42, 8'h50, 8'h00);
        send_msg("sysr", 3'b111, 4'hF, 7'h00, 7'h00, 1, 8'hFF, 8'h00, 8'h00);
        send_msg("rs_sys", 3'b001, 4'd1, 7'h40, 7'h50, 3, 8'h91, 8'h40, 8'h50);
        send_msg("rs_ch", 3'b001, 4'd2, 7'h40, 7'h50, 3, 8'h92, 8'h40, 8'h50);

        // Backpressure in DATA1 with a competing request.
        sel = 1'b0;
        @(negedge clk);
        req_cmd      = 3'b001;
        req_channel  = 4'd3;
        req_note     = 7'd60;
        req_velocity = 7'd100;
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp status", 32'(o_tx_data), 32'h93);
        @(negedge clk);
        chk("bp d1", 32'(o_tx_data), 32'h3C);
        tx_ready     = 1'b0;
        req_channel  = 4'd5;
        req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold_data%0d", i), 32'(o_tx_data), 32'h3C);
            chk($sformatf("bp hold_valid%0d", i), 32'(o_tx_valid), 32'd1);
            chk($sformatf("bp hold_ready%0d", i), 32'(o_req_ready), 32'd0);
        end
        req_valid = 1'b0;
        tx_ready  = 1'b1;
        @(negedge clk);
        chk("bp d2", 32'(o_tx_data), 32'h64);
        chk("bp d2_valid", 32'(o_tx_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp idle_valid%0d", i), 32'(o_tx_valid), 32'd0);
            chk($sformatf("bp idle_busy%0d", i), 32'(o_busy), 32'd0);
        end

        // Reset in the middle of a message on instance B.
        sel = 1'b1;
        @(negedge clk);
        req_cmd      = 3'b001;
        req_channel  = 4'd1;
        req_note     = 7'h40;
        req_velocity = 7'h50;
        req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mr status", 32'(o_tx_data), 32'h91);
        @(negedge clk);
        chk("mr d1", 32'(o_tx_data), 32'h40);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr valid", 32'(o_tx_valid), 32'd0);
        chk("mr data", 32'(o_tx_data), 32'h00);
        chk("mr busy", 32'(o_busy), 32'd0);
        chk("mr ready", 32'(o_req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr rel_ready", 32'(o_req_ready), 32'd1);
        send_msg("mr_after", 3'b001, 4'd1, 7'h40, 7'h50, 3, 8'h91, 8'h40, 8'h50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
